// File: rtl/tile_layer_mixer.sv
// tile_layer_mixer: per-pixel priority mixer between fix, A, B and sprite layers.
// Resolves the winning layer under a double-buffered priority mode, emits an
// 11-bit palette RAM index plus a pipelined blank. Mode changes written by the
// CPU are held in a shadow register and only applied at vblank start.
// Optional layer mask: define TILE_LAYER_MIXER_MASK_EN to enable REG_A=2.
module tile_layer_mixer #(
    parameter int         PIPE_STAGES   = 2,
    parameter logic [2:0] BACKDROP_BANK = 3'b111
) (
    input  logic        clk_24M,
    input  logic        nRES,
    input  logic        ce_6M,
    input  logic [11:0] DSA,
    input  logic [11:0] DSB,
    input  logic [7:0]  DFI,
    input  logic        NSAC,
    input  logic        NSBC,
    input  logic        NFIC,
    input  logic [7:0]  OBJ,
    input  logic        NOBJC,
    input  logic        NHBK,
    input  logic        NVBK,
    input  logic        REG_WR,
    input  logic [1:0]  REG_A,
    input  logic [7:0]  DB_IN,
    output logic [10:0] PAL_IDX,
    output logic        NBLANK,
    output logic [2:0]  LAYER_SEL
);

    localparam logic [2:0] SEL_FIX = 3'd0;
    localparam logic [2:0] SEL_A   = 3'd1;
    localparam logic [2:0] SEL_B   = 3'd2;
    localparam logic [2:0] SEL_OBJ = 3'd3;
    localparam logic [2:0] SEL_BD  = 3'd4;

    // Control registers
    logic [1:0] r_active_mode;
    logic [1:0] r_shadow_mode;
    logic       r_pending;
    logic [7:0] r_backdrop;
    logic       r_nvbk_q;
    logic       w_apply;

    // Stage-1 sampled pixel data
    logic [7:0] r_s1_dfi, r_s1_dsa, r_s1_dsb, r_s1_obj;
    logic       r_s1_fic, r_s1_sac, r_s1_sbc, r_s1_objc;
    logic       r_s1_nhbk, r_s1_nvbk;

    // Resolution results
    logic       w_fix_op, w_a_op, w_b_op, w_obj_op;
    logic [10:0] w_idx;
    logic [2:0]  w_sel;
    logic        w_nblank;
    logic [10:0] w_out_idx;
    logic [2:0]  w_out_sel;
    logic        w_out_nblank;

    // Output registers
    logic [10:0] r_pal_idx;
    logic        r_nblank;
    logic [2:0]  r_layer_sel;

    // Upper bits of the A/B pixel buses carry no palette information here.
    logic w_unused_hi;
    assign w_unused_hi = ^{DSA[11:8], DSB[11:8]};

    // A pending mode is committed on the falling edge of NVBK.
    assign w_apply = !NVBK && r_nvbk_q && r_pending;

    // CPU register writes and vblank-start mode commit; a mode write on the
    // commit edge lands after the commit, so pending stays set.
    always_ff @(posedge clk_24M) begin
        if (!nRES) begin
            r_active_mode <= 2'd0;
            r_shadow_mode <= 2'd0;
            r_pending     <= 1'b0;
            r_backdrop    <= 8'd0;
            r_nvbk_q      <= 1'b0;
        end else begin
            r_nvbk_q <= NVBK;
            if (w_apply) begin
                r_active_mode <= r_shadow_mode;
                r_pending     <= 1'b0;
            end
            if (REG_WR) begin
                case (REG_A)
                    2'd0: begin
                        r_shadow_mode <= DB_IN[1:0];
                        r_pending     <= 1'b1;
                    end
                    2'd1:    r_backdrop <= DB_IN;
                    default: ;
                endcase
            end
        end
    end

`ifdef TILE_LAYER_MIXER_MASK_EN
    logic [3:0] r_mask;

    // Layer mask: immediate effect, not double-buffered.
    always_ff @(posedge clk_24M) begin
        if (!nRES) begin
            r_mask <= 4'd0;
        end else if (REG_WR && REG_A == 2'd2) begin
            r_mask <= DB_IN[3:0];
        end
    end

    assign w_fix_op = r_s1_fic  & ~r_mask[0];
    assign w_a_op   = r_s1_sac  & ~r_mask[1];
    assign w_b_op   = r_s1_sbc  & ~r_mask[2];
    assign w_obj_op = r_s1_objc & ~r_mask[3];
`else
    assign w_fix_op = r_s1_fic;
    assign w_a_op   = r_s1_sac;
    assign w_b_op   = r_s1_sbc;
    assign w_obj_op = r_s1_objc;
`endif

    // Stage 1: sample the time-aligned layer pixels on each pixel strobe.
    always_ff @(posedge clk_24M) begin
        if (!nRES) begin
            r_s1_dfi  <= 8'd0;
            r_s1_dsa  <= 8'd0;
            r_s1_dsb  <= 8'd0;
            r_s1_obj  <= 8'd0;
            r_s1_fic  <= 1'b0;
            r_s1_sac  <= 1'b0;
            r_s1_sbc  <= 1'b0;
            r_s1_objc <= 1'b0;
            r_s1_nhbk <= 1'b0;
            r_s1_nvbk <= 1'b0;
        end else if (ce_6M) begin
            r_s1_dfi  <= DFI;
            r_s1_dsa  <= DSA[7:0];
            r_s1_dsb  <= DSB[7:0];
            r_s1_obj  <= OBJ;
            r_s1_fic  <= NFIC;
            r_s1_sac  <= NSAC;
            r_s1_sbc  <= NSBC;
            r_s1_objc <= NOBJC;
            r_s1_nhbk <= NHBK;
            r_s1_nvbk <= NVBK;
        end
    end

    // Stage 2 resolution: fix on top, then the mode's order, else backdrop.
    always_comb begin
        w_idx    = {BACKDROP_BANK, r_backdrop};
        w_sel    = SEL_BD;
        w_nblank = 1'b1;
        case (r_active_mode)
            2'd0: begin
                if (w_obj_op)    begin w_idx = {3'b100, r_s1_obj}; w_sel = SEL_OBJ; end
                else if (w_a_op) begin w_idx = {3'b001, r_s1_dsa}; w_sel = SEL_A;   end
                else if (w_b_op) begin w_idx = {3'b010, r_s1_dsb}; w_sel = SEL_B;   end
            end
            2'd1: begin
                if (w_a_op)        begin w_idx = {3'b001, r_s1_dsa}; w_sel = SEL_A;   end
                else if (w_obj_op) begin w_idx = {3'b100, r_s1_obj}; w_sel = SEL_OBJ; end
                else if (w_b_op)   begin w_idx = {3'b010, r_s1_dsb}; w_sel = SEL_B;   end
            end
            2'd2: begin
                if (w_obj_op)    begin w_idx = {3'b100, r_s1_obj}; w_sel = SEL_OBJ; end
                else if (w_b_op) begin w_idx = {3'b010, r_s1_dsb}; w_sel = SEL_B;   end
                else if (w_a_op) begin w_idx = {3'b001, r_s1_dsa}; w_sel = SEL_A;   end
            end
            default: begin
                if (w_b_op)        begin w_idx = {3'b010, r_s1_dsb}; w_sel = SEL_B;   end
                else if (w_obj_op) begin w_idx = {3'b100, r_s1_obj}; w_sel = SEL_OBJ; end
                else if (w_a_op)   begin w_idx = {3'b001, r_s1_dsa}; w_sel = SEL_A;   end
            end
        endcase
        if (w_fix_op) begin
            w_idx = {3'b000, r_s1_dfi};
            w_sel = SEL_FIX;
        end
        if (!r_s1_nhbk || !r_s1_nvbk) begin
            w_idx    = 11'd0;
            w_sel    = SEL_BD;
            w_nblank = 1'b0;
        end
    end

    generate
        if (PIPE_STAGES == 3) begin : g_retime
            logic [10:0] r_s2_idx;
            logic [2:0]  r_s2_sel;
            logic        r_s2_nblank;

            // Extra retiming stage between resolution and the output register.
            always_ff @(posedge clk_24M) begin
                if (!nRES) begin
                    r_s2_idx    <= 11'd0;
                    r_s2_sel    <= SEL_BD;
                    r_s2_nblank <= 1'b0;
                end else if (ce_6M) begin
                    r_s2_idx    <= w_idx;
                    r_s2_sel    <= w_sel;
                    r_s2_nblank <= w_nblank;
                end
            end

            assign w_out_idx    = r_s2_idx;
            assign w_out_sel    = r_s2_sel;
            assign w_out_nblank = r_s2_nblank;
        end else begin : g_direct
            assign w_out_idx    = w_idx;
            assign w_out_sel    = w_sel;
            assign w_out_nblank = w_nblank;
        end
    endgenerate

    // Output register: holds between pixel strobes.
    always_ff @(posedge clk_24M) begin
        if (!nRES) begin
            r_pal_idx   <= 11'd0;
            r_nblank    <= 1'b0;
            r_layer_sel <= SEL_BD;
        end else if (ce_6M) begin
            r_pal_idx   <= w_out_idx;
            r_nblank    <= w_out_nblank;
            r_layer_sel <= w_out_sel;
        end
    end

    assign PAL_IDX   = r_pal_idx;
    assign NBLANK    = r_nblank;
    assign LAYER_SEL = r_layer_sel;

endmodule

// File: tb/tb_tile_layer_mixer.sv
// Testbench for tile_layer_mixer: directed priority/mode/blank scenarios and
// randomized traffic, checked every cycle against a behavioural model.
module tb_tile_layer_mixer;

    localparam int         PIPE_STAGES   = 2;
    localparam logic [2:0] BACKDROP_BANK = 3'b111;

    logic        clk_24M = 1'b0;
    logic        nRES    = 1'b0;
    logic        ce_6M   = 1'b0;
    logic [11:0] DSA     = '0;
    logic [11:0] DSB     = '0;
    logic [7:0]  DFI     = '0;
    logic        NSAC    = 1'b0;
    logic        NSBC    = 1'b0;
    logic        NFIC    = 1'b0;
    logic [7:0]  OBJ     = '0;
    logic        NOBJC   = 1'b0;
    logic        NHBK    = 1'b1;
    logic        NVBK    = 1'b1;
    logic        REG_WR  = 1'b0;
    logic [1:0]  REG_A   = '0;
    logic [7:0]  DB_IN   = '0;
    logic [10:0] PAL_IDX;
    logic        NBLANK;
    logic [2:0]  LAYER_SEL;

    tile_layer_mixer #(
        .PIPE_STAGES  (PIPE_STAGES),
        .BACKDROP_BANK(BACKDROP_BANK)
    ) dut (
        .clk_24M  (clk_24M),
        .nRES     (nRES),
        .ce_6M    (ce_6M),
        .DSA      (DSA),
        .DSB      (DSB),
        .DFI      (DFI),
        .NSAC     (NSAC),
        .NSBC     (NSBC),
        .NFIC     (NFIC),
        .OBJ      (OBJ),
        .NOBJC    (NOBJC),
        .NHBK     (NHBK),
        .NVBK     (NVBK),
        .REG_WR   (REG_WR),
        .REG_A    (REG_A),
        .DB_IN    (DB_IN),
        .PAL_IDX  (PAL_IDX),
        .NBLANK   (NBLANK),
        .LAYER_SEL(LAYER_SEL)
    );

    // Clock
    always #5 clk_24M = ~clk_24M;

    typedef struct packed {
        logic [7:0] dfi, dsa, dsb, obj;
        logic       fic, sac, sbc, objc, nhbk, nvbk;
    } pix_t;

    typedef struct packed {
        logic [10:0] idx;
        logic [2:0]  sel;
        logic        nb;
    } out_t;

    // Behavioural model state
    pix_t       m_s1;
    logic [1:0] m_active, m_shadow;
    logic       m_pending, m_nvbk_prev;
    logic [7:0] m_backdrop;
    logic [3:0] m_mask;
    out_t       m_out;
    out_t       res_q[$];
    bit         model_valid = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int phase    = 0;
    bit last_strobe;

    // Priority order below fix, by mode; layer ids 0 fix, 1 A, 2 B, 3 OBJ.
    function automatic out_t resolve(pix_t p, logic [1:0] mode, logic [3:0] mask, logic [7:0] bd);
        out_t        o;
        logic [3:0]  opq;
        logic [10:0] code [4];
        int          order [4][3];
        bit          found;
        order   = '{'{3, 1, 2}, '{1, 3, 2}, '{3, 2, 1}, '{2, 3, 1}};
        opq     = {p.objc, p.sbc, p.sac, p.fic} & ~mask;
        code[0] = {3'b000, p.dfi};
        code[1] = {3'b001, p.dsa};
        code[2] = {3'b010, p.dsb};
        code[3] = {3'b100, p.obj};
        o.idx = {BACKDROP_BANK, bd};
        o.sel = 3'd4;
        o.nb  = 1'b1;
        found = 1'b0;
        if (opq[0]) begin
            o.idx = code[0];
            o.sel = 3'd0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!found && opq[order[mode][k]]) begin
                    found = 1'b1;
                    o.idx = code[order[mode][k]];
                    o.sel = 3'(order[mode][k]);
                end
            end
        end
        if (!p.nhbk || !p.nvbk) begin
            o.idx = 11'd0;
            o.sel = 3'd4;
            o.nb  = 1'b0;
        end
        return o;
    endfunction

    task automatic model_reset();
        m_s1        = '0;
        m_active    = 2'd0;
        m_shadow    = 2'd0;
        m_pending   = 1'b0;
        m_nvbk_prev = 1'b0;
        m_backdrop  = 8'd0;
        m_mask      = 4'd0;
        m_out.idx   = 11'd0;
        m_out.sel   = 3'd4;
        m_out.nb    = 1'b0;
        res_q.delete();
        for (int i = 0; i < PIPE_STAGES - 2; i++) res_q.push_back(m_out);
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        bit   apply;
        pix_t cur;
        if (!nRES) begin
            model_reset();
        end else begin
            apply = !NVBK && m_nvbk_prev && m_pending;
            if (ce_6M) begin
                res_q.push_back(resolve(m_s1, m_active, m_mask, m_backdrop));
                m_out = res_q.pop_front();
                cur = '{dfi: DFI, dsa: DSA[7:0], dsb: DSB[7:0], obj: OBJ, fic: NFIC,
                        sac: NSAC, sbc: NSBC, objc: NOBJC, nhbk: NHBK, nvbk: NVBK};
                m_s1 = cur;
            end
            m_nvbk_prev = NVBK;
            if (apply) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
            end
            if (REG_WR && REG_A == 2'd0) begin
                m_shadow  = DB_IN[1:0];
                m_pending = 1'b1;
            end
            if (REG_WR && REG_A == 2'd1) m_backdrop = DB_IN;
`ifdef TILE_LAYER_MIXER_MASK_EN
            if (REG_WR && REG_A == 2'd2) m_mask = DB_IN[3:0];
`endif
        end
        model_valid = 1'b1;
    endtask

    // Scoreboard compare on the falling edge, every cycle once the model is live.
    always @(negedge clk_24M) begin
        if (model_valid) begin
            n_checks++;
            if (PAL_IDX === m_out.idx && LAYER_SEL === m_out.sel && NBLANK === m_out.nb) begin
                n_pass++;
            end else begin
                $display("FAIL cycle_cmp t=%0t pal=%h exp=%h sel=%0d exp=%0d nblank=%b exp=%b",
                         $time, PAL_IDX, m_out.idx, LAYER_SEL, m_out.sel, NBLANK, m_out.nb);
            end
        end
    end

    task automatic check_lit(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", name, act, exp);
    endtask

    // One clock: ce_6M on every 4th cycle.
    task automatic tick();
        ce_6M = (phase == 3);
        last_strobe = ce_6M;
        @(posedge clk_24M);
        model_step();
        phase = (phase + 1) % 4;
        #1;
    endtask

    // Present one pixel and run until it has been sampled by a strobe.
    task automatic pixel(input logic [7:0] fi, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] o, input logic [3:0] opq, input logic hb, input logic vb);
        DFI   = fi;
        DSA   = {4'($urandom), a};
        DSB   = {4'($urandom), b};
        OBJ   = o;
        NFIC  = opq[0];
        NSAC  = opq[1];
        NSBC  = opq[2];
        NOBJC = opq[3];
        NHBK  = hb;
        NVBK  = vb;
        do tick(); while (!last_strobe);
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
        REG_WR = 1'b1;
        REG_A  = a;
        DB_IN  = d;
        tick();
        REG_WR = 1'b0;
    endtask

    logic [10:0] exp_mask;
    int          blank_exp [5];

    initial begin
        // Reset with random inputs
        nRES = 1'b0;
        for (int i = 0; i < 8; i++) begin
            DFI = 8'($urandom); OBJ = 8'($urandom);
            DSA = 12'($urandom); DSB = 12'($urandom);
            {NFIC, NSAC, NSBC, NOBJC, NHBK, NVBK} = 6'($urandom);
            tick();
        end
        check_lit("reset_pal", PAL_IDX, 11'h000);
        check_lit("reset_nblank", {10'd0, NBLANK}, 11'd0);
        check_lit("reset_sel", {8'd0, LAYER_SEL}, 11'd4);

        // Release, backdrop 5A, all transparent
        nRES = 1'b1;
        {NFIC, NSAC, NSBC, NOBJC} = 4'b0000;
        NHBK = 1'b1; NVBK = 1'b1;
        reg_write(2'd1, 8'h5A);
        pixel(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b1, 1'b1);
        pixel(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b1, 1'b1);
        check_lit("backdrop", PAL_IDX, 11'h75A);

        // Mode 0 priority
        pixel(8'h12, 8'h34, 8'h78, 8'h56, 4'b1111, 1'b1, 1'b1);
        pixel(8'h12, 8'h34, 8'h78, 8'h56, 4'b1110, 1'b1, 1'b1);
        check_lit("m0_fix", PAL_IDX, 11'h012);
        pixel(8'h12, 8'h34, 8'h78, 8'h56, 4'b0110, 1'b1, 1'b1);
        check_lit("m0_obj", PAL_IDX, 11'h456);
        pixel(8'h12, 8'h34, 8'h78, 8'h56, 4'b0110, 1'b1, 1'b1);
        check_lit("m0_a", PAL_IDX, 11'h134);

        // Deferred mode 3
        reg_write(2'd0, 8'h03);
        pixel(8'h12, 8'h34, 8'h78, 8'h56, 4'b1110, 1'b1, 1'b1);
        pixel(8'h12, 8'h34, 8'h78, 8'h56, 4'b1110, 1'b1, 1'b1);
        check_lit("defer_hold", PAL_IDX, 11'h456);
        pixel(8'h12, 8'h34, 8'h78, 8'h56, 4'b1110, 1'b1, 1'b0);
        pixel(8'h12, 8'h34, 8'h78, 8'h56, 4'b1110, 1'b1, 1'b1);
        check_lit("vblank_blank", {10'd0, NBLANK}, 11'd0);
        pixel(8'h12, 8'h34, 8'h78, 8'h56, 4'b1110, 1'b1, 1'b1);
        check_lit("defer_applied", PAL_IDX, 11'h278);

        // Collision: mode 2 written on the same edge mode 1 is applied
        reg_write(2'd0, 8'h01);
        pixel(8'h12, 8'h34, 8'h78, 8'h56, 4'b0110, 1'b1, 1'b1);
        NVBK = 1'b0;
        reg_write(2'd0, 8'h02);
        pixel(8'h12, 8'h34, 8'h78, 8'h56, 4'b0110, 1'b1, 1'b0);
        pixel(8'h12, 8'h34, 8'h78, 8'h56, 4'b0110, 1'b1, 1'b1);
        pixel(8'h12, 8'h34, 8'h78, 8'h56, 4'b0110, 1'b1, 1'b1);
        check_lit("collide_mode1", PAL_IDX, 11'h134);
        pixel(8'h12, 8'h34, 8'h78, 8'h56, 4'b0110, 1'b1, 1'b0);
        pixel(8'h12, 8'h34, 8'h78, 8'h56, 4'b0110, 1'b1, 1'b1);
        pixel(8'h12, 8'h34, 8'h78, 8'h56, 4'b0110, 1'b1, 1'b1);
        check_lit("collide_mode2", PAL_IDX, 11'h278);

        // Horizontal blank for 3 strobes
        blank_exp = '{1, 0, 0, 0, 1};
        pixel(8'h12, 8'h34, 8'h78, 8'h56, 4'b1111, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            pixel(8'h12, 8'h34, 8'h78, 8'h56, 4'b1111, (i >= 3), 1'b1);
            check_lit($sformatf("hblank_nb%0d", i), {10'd0, NBLANK}, 11'(blank_exp[i]));
            check_lit($sformatf("hblank_pal%0d", i), PAL_IDX, (blank_exp[i] != 0) ? 11'h012 : 11'h000);
        end

        // Layer mask on fix
`ifdef TILE_LAYER_MIXER_MASK_EN
        exp_mask = 11'h134;
`else
        exp_mask = 11'h012;
`endif
        reg_write(2'd2, 8'h01);
        pixel(8'h12, 8'h34, 8'h78, 8'h56, 4'b0011, 1'b1, 1'b1);
        pixel(8'h12, 8'h34, 8'h78, 8'h56, 4'b0011, 1'b1, 1'b1);
        check_lit("mask_fix", PAL_IDX, exp_mask);
        reg_write(2'd2, 8'h00);

        // Randomized traffic with register writes, blanks and a mid-run reset
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                nRES = 1'b0;
                repeat (3) tick();
                nRES = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) reg_write(2'($urandom), 8'($urandom));
            pixel(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                  ($urandom_range(0, 9) != 0), ($urandom_range(0, 11) != 0));
        end
        repeat (8) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tile_layer_mixer.md
Name: tile_layer_mixer

Overview:
- Downstream of the plane data processor.
- Takes the time-aligned fix, A and B layer pixels plus their opacity flags, and a sprite pixel.
- Resolves per-pixel layer priority under a CPU-programmable mode and emits an 11-bit palette RAM index with pipelined blanking.
- Priority-mode changes are double-buffered and applied only at vblank start, so there is no mid-frame tearing.

Parameters:
- PIPE_STAGES, 2, pixel-strobe latency from input sample to PAL_IDX; legal values 2 or 3 (3 adds an output retiming register).
- BACKDROP_BANK, 3'b111, upper 3 bits of PAL_IDX when every layer is transparent.

Ports:
- clk_24M  in  1  system clock.
- nRES  in  1  synchronous active-low reset.
- ce_6M  in  1  pixel strobe, one clk_24M cycle wide, every 4th cycle.
- DSA  in  12  layer A pixel; [7:0] is used.
- DSB  in  12  layer B pixel; [7:0] is used.
- DFI  in  8  fix layer pixel.
- NSAC  in  1  layer A opaque (1 = opaque).
- NSBC  in  1  layer B opaque.
- NFIC  in  1  fix opaque.
- OBJ  in  8  sprite pixel.
- NOBJC  in  1  sprite opaque.
- NHBK  in  1  horizontal blank, active low.
- NVBK  in  1  vertical blank, active low.
- REG_WR  in  1  register write strobe, one clk_24M cycle.
- REG_A  in  2  register select.
- DB_IN  in  8  register write data.
- PAL_IDX  out  11  palette RAM index.
- NBLANK  out  1  pipelined blank, low = blank.
- LAYER_SEL  out  3  winning layer: 0 fix, 1 A, 2 B, 3 OBJ, 4 backdrop.

Behaviour:
- Reset (nRES low at a clk_24M edge): PAL_IDX=0, NBLANK=0, LAYER_SEL=4, active mode=0, shadow mode=0, pending=0, backdrop=0, mask=0.
- All pipeline registers advance only on clk_24M edges where ce_6M=1. Register writes act on any edge with REG_WR=1.
- Register map:
  - REG_A=0: DB_IN[1:0] written to shadow mode; pending set to 1.
  - REG_A=1: DB_IN[7:0] written directly to backdrop colour.
  - REG_A=2: layer mask, see Optional Feature.
  - REG_A=3: ignored.
- Mode apply:
  - The block keeps a registered copy of NVBK, sampled on every clk_24M edge.
  - On the edge where NVBK is 0 and its registered copy is 1 (vblank start) and pending=1: active mode <= shadow mode, pending <= 0.
  - Simultaneous apply and REG_A=0 write: active mode gets the old shadow value, shadow takes the new data, pending stays 1.
- Stage 1 (strobe N): sample all pixel inputs, opacity flags, NHBK, NVBK.
- Stage 2 (strobe N+1): resolve the winner from stage-1 data using the active mode. Fix, when opaque, always wins. Below fix, first opaque layer in this order:
  - mode 0: OBJ > A > B
  - mode 1: A > OBJ > B
  - mode 2: OBJ > B > A
  - mode 3: B > OBJ > A
  - none opaque: backdrop.
- Index encoding:
  - fix {3'b000,DFI}
  - A {3'b001,DSA[7:0]}
  - B {3'b010,DSB[7:0]}
  - OBJ {3'b100,OBJ}
  - backdrop {BACKDROP_BANK,backdrop}
- Blank: if stage-1 NHBK=0 or NVBK=0, PAL_IDX=0, LAYER_SEL=4 and NBLANK=0. Otherwise NBLANK=1.
- Latency: inputs sampled at strobe N appear on the outputs after the clk_24M edge of strobe N+1 when PIPE_STAGES=2, or strobe N+2 when PIPE_STAGES=3. Outputs hold between strobes.
- The mode used for a pixel is the active mode at its stage-2 strobe.
- Reset asserted mid-line: the pipeline flushes to reset values on the next edge, independent of ce_6M.

Optional Feature:
- Macro: TILE_LAYER_MIXER_MASK_EN.
- Defined: REG_A=2 writes DB_IN[3:0] to the mask: bit0 fix, bit1 A, bit2 B, bit3 OBJ. A set bit forces that layer's opacity to 0 before resolution. The mask takes effect immediately, is not double-buffered, and resets to 0.
- Undefined: REG_A=2 writes are ignored and there is no mask logic.

Test Plan:
1. Reset: hold nRES low 8 cycles with random inputs -> PAL_IDX=0, NBLANK=0, LAYER_SEL=4. Release with all layers transparent, backdrop written 8'h5A, NHBK=NVBK=1 -> PAL_IDX=11'h75A two strobes later (PIPE_STAGES=2).
2. Priority mode 0: DFI=8'h12 opaque, A=8'h34 opaque, OBJ=8'h56 opaque, B opaque -> PAL_IDX=11'h012. Next pixel NFIC=0 -> 11'h456. Next pixel NFIC=0, NOBJC=0 -> 11'h134.
3. Deferred mode: write mode 3 mid-frame with A, B, OBJ opaque and fix transparent -> output stays OBJ (11'h4xx) until the vblank-start edge. After the apply, with NVBK back high -> B wins (11'h2xx), pending=0.
4. Collision: REG_A=0 write of mode 2 on the exact vblank-start edge while shadow=1 and pending=1 -> active=1, shadow=2, pending stays 1. The next vblank start applies 2.
5. Blanking: drive NHBK=0 for 3 strobes with opaque layers -> NBLANK=0 and PAL_IDX=0 for exactly 3 output strobes, aligned to the pipeline latency.
6. With TILE_LAYER_MIXER_MASK_EN: mask=4'b0001, fix and A opaque -> A wins. Without the macro, the same write leaves fix winning.
